// File: rtl/router_ctrl.sv
// rtl/router_ctrl.sv - router write-side controller FSM with per-destination FIFO steering.
// Optional per-destination read watchdog enabled by defining ROUTER_CTRL_WATCHDOG_EN.
module router_ctrl #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       sel_full,
  output logic [2:0] write_enb,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;
  logic       empty_sel, soft_reset_sel;

  // addr never holds 2'b11, so the default arms are unreachable
  always_comb begin
    sel_full       = 1'b0;
    empty_sel      = 1'b0;
    soft_reset_sel = 1'b0;
    case (addr)
      2'd0: begin sel_full = fifo_full[0]; empty_sel = fifo_empty[0]; soft_reset_sel = soft_reset[0]; end
      2'd1: begin sel_full = fifo_full[1]; empty_sel = fifo_empty[1]; soft_reset_sel = soft_reset[1]; end
      2'd2: begin sel_full = fifo_full[2]; empty_sel = fifo_empty[2]; soft_reset_sel = soft_reset[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid && data_in != 2'b11)
        addr <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (pkt_valid && data_in != 2'b11)
          next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    next_state = LOAD_DATA;
      LOAD_DATA:
        if (sel_full)        next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:    next_state = sel_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    next_state = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      default:            next_state = DECODE_ADDRESS;
    endcase
    if (soft_reset_sel)
      next_state = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

  assign write_enb = write_enb_reg ? (3'b001 << addr) : 3'b000;
  assign vld_out   = ~fifo_empty;

`ifdef ROUTER_CTRL_WATCHDOG_EN
  localparam logic [4:0] WD_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] wd_cnt [3];

  // A pulse restarts the count, so a reader that stays stalled gets re-flagged every TIMEOUT_CYCLES
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      soft_reset <= 3'b000;
      for (int k = 0; k < 3; k++) wd_cnt[k] <= 5'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (vld_out[k] && !read_enb[k]) begin
          soft_reset[k] <= (wd_cnt[k] == WD_LAST);
          wd_cnt[k]     <= (wd_cnt[k] == WD_LAST) ? 5'd0 : wd_cnt[k] + 5'd1;
        end else begin
          soft_reset[k] <= 1'b0;
          wd_cnt[k]     <= 5'd0;
        end
      end
    end
  end
`else
  logic unused_read_enb;
  assign unused_read_enb = ^read_enb;
  assign soft_reset      = 3'b000;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// tb/tb_router_ctrl.sv - directed vector table plus randomized reference-model check of router_ctrl.
module tb_router_ctrl;

  localparam int T = 30;
  localparam int DA = 0, LFD = 1, LD = 2, FULL = 3, LAF = 4, LP = 5, CPE = 6, WTE = 7;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic [2:0] fifo_full = 3'b000, fifo_empty = 3'b111, read_enb = 3'b111;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, sel_full;
  logic [2:0] write_enb, vld_out, soft_reset;

  int total = 0;
  int bad = 0;

  router_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .read_enb(read_enb), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .sel_full(sel_full),
    .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  // {busy, write_enb_reg, rst_int_reg, full, laf, ld, lfd, detect_add}
  function automatic logic [7:0] flags_of(int st);
    case (st)
      DA:      return 8'b0000_0001;
      LFD:     return 8'b1000_0010;
      LD:      return 8'b0100_0100;
      FULL:    return 8'b1001_0000;
      LAF:     return 8'b1100_1000;
      LP:      return 8'b1100_0000;
      CPE:     return 8'b1010_0000;
      default: return 8'b1000_0000;
    endcase
  endfunction

  function automatic int model_next(int st, int a, logic pv, logic [1:0] din, logic pd, logic lpv,
                                    logic [2:0] ff, logic [2:0] fe, logic [2:0] sr);
    if (sr[a]) return DA;
    case (st)
      DA:      return (pv && din != 2'b11) ? (fe[din] ? LFD : WTE) : DA;
      LFD:     return LD;
      LD:      return ff[a] ? FULL : (!pv ? LP : LD);
      FULL:    return ff[a] ? FULL : LAF;
      LAF:     return pd ? DA : (lpv ? LP : LD);
      LP:      return CPE;
      CPE:     return ff[a] ? FULL : DA;
      default: return fe[a] ? LFD : WTE;
    endcase
  endfunction

  task automatic check(string name, int st, logic [2:0] exp_we, logic exp_sf, logic [2:0] exp_sr);
    logic [7:0] got, exp;
    got = {busy, write_enb_reg, rst_int_reg, full_state, laf_state, ld_state, lfd_state, detect_add};
    exp = flags_of(st);
    total++;
    if (got !== exp || write_enb !== exp_we || sel_full !== exp_sf ||
        vld_out !== ~fifo_empty || soft_reset !== exp_sr) begin
      bad++;
      $display("FAIL %s: got flags=%b we=%b sf=%b vld=%b sr=%b want flags=%b we=%b sf=%b vld=%b sr=%b",
               name, got, write_enb, sel_full, vld_out, soft_reset, exp, exp_we, exp_sf, ~fifo_empty, exp_sr);
    end
  endtask

  typedef struct {
    logic pv; logic [1:0] din; logic pd; logic lpv;
    logic [2:0] ff; logic [2:0] fe;
    int st; logic [2:0] we; logic sf;
  } vec_t;

  vec_t vecs[$];

  int mst, maddr;
  int run [3];
  logic [2:0] msr;

  initial begin
    //         pv   din    pd    lpv   ff      fe      state we      sf
    vecs.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, DA,   3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LFD,  3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 3'b111, LD,   3'b010, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 3'b111, FULL, 3'b000, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, FULL, 3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 3'b111, LAF,  3'b010, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, DA,   3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LFD,  3'b000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LD,   3'b010, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LP,   3'b010, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, CPE,  3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b101, DA,   3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b101, WTE,  3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, WTE,  3'b000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LFD,  3'b000, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LD,   3'b010, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LP,   3'b010, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, CPE,  3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 3'b000, 3'b111, DA,   3'b000, 1'b0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 1'b0, 3'b010, 3'b111, DA,   3'b000, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b111, DA,   3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LFD,  3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b100, 3'b111, LD,   3'b100, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, FULL, 3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 3'b111, LAF,  3'b100, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b100, 3'b111, LP,   3'b100, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b100, 3'b111, CPE,  3'b000, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, FULL, 3'b000, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LAF,  3'b100, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, LD,   3'b100, 1'b0});

    // reset state, then directed table
    repeat (2) @(negedge clock);
    #1 check("reset", DA, 3'b000, 1'b0, 3'b000);
    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      pkt_valid = vecs[i].pv; data_in = vecs[i].din; parity_done = vecs[i].pd;
      low_pkt_valid = vecs[i].lpv; fifo_full = vecs[i].ff; fifo_empty = vecs[i].fe;
      #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].we, vecs[i].sf, 3'b000);
    end

    // asynchronous reset mid-packet: takes effect without a clock edge
    @(negedge clock);
    pkt_valid = 1'b1; fifo_full = 3'b000;
    #1 check("pre_async_rst", LD, 3'b100, 1'b0, 3'b000);
    #2 resetn = 1'b0;
    #1 check("async_rst", DA, 3'b000, 1'b0, 3'b000);
    @(negedge clock);
    resetn = 1'b1; pkt_valid = 1'b0;
    @(negedge clock);
    #1 check("post_rst_idle", DA, 3'b000, 1'b0, 3'b000);

`ifdef ROUTER_CTRL_WATCHDOG_EN
    // fifo 2 holds data with no reader: one pulse after T stalled cycles
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1; fifo_empty = 3'b011; read_enb = 3'b000;
    repeat (T - 1) @(posedge clock);
    @(negedge clock);
    #1 check("wd_before", DA, 3'b000, 1'b0, 3'b000);
    @(negedge clock);
    #1 check("wd_pulse", DA, 3'b000, 1'b0, 3'b100);
    @(negedge clock);
    #1 check("wd_pulse_end", DA, 3'b000, 1'b0, 3'b000);
    read_enb = 3'b100;
    @(negedge clock);
    read_enb = 3'b000;
    repeat (T - 1) @(posedge clock);
    @(negedge clock);
    read_enb = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1 check("wd_read_late", DA, 3'b000, 1'b0, 3'b000);
    end
    read_enb = 3'b111;
`endif

    // randomized run against reference model
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    mst = DA; maddr = 0; msr = 3'b000;
    for (int k = 0; k < 3; k++) run[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      int nxt;
      @(negedge clock);
      pkt_valid = ($urandom % 4) != 0;
      data_in = 2'($urandom % 4);
      parity_done = ($urandom % 4) == 0;
      low_pkt_valid = 1'($urandom % 2);
      for (int k = 0; k < 3; k++) begin
        fifo_full[k] = ($urandom % 4) == 0;
        fifo_empty[k] = 1'($urandom % 2);
        read_enb[k] = ($urandom % 8) != 0;
      end
      #1 check("rand", mst, flags_of(mst)[6] ? 3'(1 << maddr) : 3'b000, fifo_full[maddr], msr);
      nxt = model_next(mst, maddr, pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, msr);
      if (mst == DA && pkt_valid && data_in != 2'b11) maddr = int'(data_in);
      mst = nxt;
`ifdef ROUTER_CTRL_WATCHDOG_EN
      for (int k = 0; k < 3; k++) begin
        run[k] = (!fifo_empty[k] && !read_enb[k]) ? run[k] + 1 : 0;
        msr[k] = (run[k] > 0) && (run[k] % T == 0);
      end
`endif
      @(posedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
